// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the single-clock FIFO.
package fifo_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefLog2Depth = 4;

  function automatic int unsigned fifo_depth(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Bundle of the FIFO's clock, reset and push/pop signals, port-compatible with fifo.
interface fifo_if #(
  parameter int unsigned data_width           = 8,
  parameter int unsigned length_as_power_of_2 = 4
);
  logic                  clock;
  logic                  reset;
  logic [data_width-1:0] data_in;
  logic                  read_enable;
  logic                  write_enable;
  logic [data_width-1:0] data_out;
  logic                  full;
  logic                  empty;

  modport DUT (
    input  clock, reset, data_in, read_enable, write_enable,
    output data_out, full, empty
  );

  modport DRIVER (
    output clock, reset, data_in, read_enable, write_enable,
    input  data_out, full, empty
  );

  modport MONITOR (
    input clock, reset, data_in, read_enable, write_enable, data_out, full, empty
  );
endinterface

// File: rtl/fifo.sv
// Single-clock FIFO; read_enable pushes data_in, write_enable pops into registered data_out.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned data_width           = DefDataWidth,
  parameter int unsigned length_as_power_of_2 = DefLog2Depth
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [data_width-1:0] data_in,
  input  logic                  read_enable,
  input  logic                  write_enable,
  output logic [data_width-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = fifo_depth(length_as_power_of_2);
  localparam int unsigned PtrW  = length_as_power_of_2;
  localparam int unsigned CntW  = length_as_power_of_2 + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [data_width-1:0] mem_q [Depth];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  push_ok, pop_ok;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  always_comb begin
    push_ok = read_enable & ~full;
    pop_ok  = write_enable & ~empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dout_d  = '0;  // no stale word: data_out is zero on any edge without a pop
    if (push_ok) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PtrW'(1);
      dout_d = mem_q[rptr_q];
    end
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_in;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_fifo.sv
// Directed plus random checks of fifo against a queue-based reference model.
module tb_fifo;

  localparam int unsigned Dw    = 8;
  localparam int unsigned Lg    = 2;
  localparam int unsigned Depth = 4;

  fifo_if #(.data_width(Dw), .length_as_power_of_2(Lg)) ifc ();

  fifo #(.data_width(Dw), .length_as_power_of_2(Lg)) dut (
    .clock        (ifc.clock),
    .reset        (ifc.reset),
    .data_in      (ifc.data_in),
    .read_enable  (ifc.read_enable),
    .write_enable (ifc.write_enable),
    .data_out     (ifc.data_out),
    .full         (ifc.full),
    .empty        (ifc.empty)
  );

  int unsigned    checks = 0;
  int unsigned    passes = 0;
  logic [Dw-1:0]  model_q[$];
  logic [Dw-1:0]  exp_dout = '0;

  initial ifc.clock = 1'b0;
  always #5 ifc.clock = ~ifc.clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"}, 32'(ifc.data_out), 32'(exp_dout));
    check({tag, ".full"}, 32'(ifc.full), 32'(model_q.size() == Depth));
    check({tag, ".empty"}, 32'(ifc.empty), 32'(model_q.size() == 0));
  endtask

  // Drives one cycle of push/pop, advances the model at the edge, checks #1 later.
  task automatic cycle(input logic push, input logic pop, input logic [Dw-1:0] d,
                       input string tag);
    bit push_ok, pop_ok;
    ifc.read_enable  = push;
    ifc.write_enable = pop;
    ifc.data_in      = d;
    push_ok = push && (model_q.size() < Depth);
    pop_ok  = pop && (model_q.size() > 0);
    @(posedge ifc.clock);
    exp_dout = pop_ok ? model_q.pop_front() : '0;
    if (push_ok) model_q.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    ifc.reset        = 1'b1;
    ifc.read_enable  = 1'b0;
    ifc.write_enable = 1'b0;
    ifc.data_in      = '0;
    #12;
    ifc.reset = 1'b0;
    cycle(1'b0, 1'b0, 8'h00, "reset");

    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i), "fill");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, "drain");
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, "underflow");

    cycle(1'b1, 1'b0, 8'hA1, "pushA");
    cycle(1'b1, 1'b0, 8'hB2, "pushB");
    cycle(1'b1, 1'b1, 8'hC3, "pushC_popA");
    cycle(1'b0, 1'b1, 8'h00, "popB");
    cycle(1'b0, 1'b1, 8'h00, "popC");
    cycle(1'b1, 1'b1, 8'h5E, "pushpop_empty");
    cycle(1'b0, 1'b1, 8'h00, "pop_5E");

    cycle(1'b1, 1'b0, 8'h11, "pre_rst1");
    cycle(1'b1, 1'b0, 8'h22, "pre_rst2");
    cycle(1'b1, 1'b0, 8'h33, "pre_rst3");
    cycle(1'b1, 1'b1, 8'h44, "pre_rst4");
    #2;
    ifc.reset = 1'b1;
    #1;
    model_q.delete();
    exp_dout = '0;
    check_all("async_rst");
    #2;
    ifc.reset = 1'b0;
    cycle(1'b0, 1'b1, 8'h00, "pop_after_rst");

    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
